// File: rtl/hazard_pipe_reg.sv
// Hazard sideband pipeline register: stall/flush/bubble, Tnew aging,
// and the producer-match check the hazard unit uses per stage.
module hazard_pipe_reg #(
    parameter int              AW     = 5,
    parameter int              RESW   = 2,
    parameter int              TW     = 2,
    parameter logic [RESW-1:0] RES_NW = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            valid_i,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [RESW-1:0] res_i,
    input  logic [TW-1:0]   tnew_i,
    output logic            valid_o,
    output logic [AW-1:0]   ra1_o,
    output logic [AW-1:0]   ra2_o,
    output logic [AW-1:0]   wa_o,
    output logic [RESW-1:0] res_o,
    output logic [TW-1:0]   tnew_o,
    input  logic [AW-1:0]   q1,
    input  logic [AW-1:0]   q2,
    output logic            hit1,
    output logic            hit2,
    output logic            fwd1,
    output logic            fwd2,
    output logic            stall_req
);

    logic            wr_en;
    logic [AW-1:0]   wa_n;
    logic [RESW-1:0] res_n;
    logic [TW-1:0]   tnew_n;

    // Non-writing slots are canonicalised so the match logic sees one form.
    always_comb begin
        wr_en  = valid_i && (wa_i != '0) && (res_i != RES_NW);
        wa_n   = wr_en ? wa_i : '0;
        res_n  = wr_en ? res_i : RES_NW;
        tnew_n = (tnew_i == '0) ? '0 : tnew_i - TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_o <= 1'b0;
            ra1_o   <= '0;
            ra2_o   <= '0;
            wa_o    <= '0;
            res_o   <= RES_NW;
            tnew_o  <= '0;
        end else if (!stall) begin
            valid_o <= valid_i;
            ra1_o   <= ra1_i;
            ra2_o   <= ra2_i;
            wa_o    <= wa_n;
            res_o   <= res_n;
            tnew_o  <= tnew_n;
        end
    end

    logic writes;
    logic ready;

    // The wa_o != 0 term is a redundant guard for register $0.
    always_comb begin
        writes    = valid_o && (res_o != RES_NW) && (wa_o != '0);
        ready     = (tnew_o == '0);
        hit1      = writes && (wa_o == q1);
        hit2      = writes && (wa_o == q2);
        fwd1      = hit1 && ready;
        fwd2      = hit2 && ready;
        stall_req = (hit1 || hit2) && !ready;
    end

endmodule

// File: tb/tb_hazard_pipe_reg.sv
// Scoreboard bench for hazard_pipe_reg: directed vectors push expected
// post-edge state; a monitor pops and compares after every edge.
module tb_hazard_pipe_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       valid_i = 1'b0;
    logic [4:0] ra1_i = '0, ra2_i = '0, wa_i = '0, q1 = '0, q2 = '0;
    logic [1:0] res_i = '0, tnew_i = '0;
    logic       valid_o;
    logic [4:0] ra1_o, ra2_o, wa_o;
    logic [1:0] res_o, tnew_o;
    logic       hit1, hit2, fwd1, fwd2, stall_req;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         id;
        logic       v;
        logic [4:0] ra1, ra2, wa;
        logic [1:0] res, tnew;
        logic       h1, h2, f1, f2, sr;
    } exp_t;

    exp_t sb[$];

    hazard_pipe_reg #(.AW(5), .RESW(2), .TW(2), .RES_NW(2'd0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_i(valid_i), .ra1_i(ra1_i), .ra2_i(ra2_i), .wa_i(wa_i),
        .res_i(res_i), .tnew_i(tnew_i),
        .valid_o(valid_o), .ra1_o(ra1_o), .ra2_o(ra2_o), .wa_o(wa_o),
        .res_o(res_o), .tnew_o(tnew_o),
        .q1(q1), .q2(q2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm,
                       input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL vec%0d %s: got %0h expected %0h", id, nm, act, expv);
        end
    endtask

    // Monitor: compare registered state and match outputs after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "valid_o", 8'(valid_o), 8'(e.v));
                chk(e.id, "ra1_o", 8'(ra1_o), 8'(e.ra1));
                chk(e.id, "ra2_o", 8'(ra2_o), 8'(e.ra2));
                chk(e.id, "wa_o", 8'(wa_o), 8'(e.wa));
                chk(e.id, "res_o", 8'(res_o), 8'(e.res));
                chk(e.id, "tnew_o", 8'(tnew_o), 8'(e.tnew));
                chk(e.id, "hit1", 8'(hit1), 8'(e.h1));
                chk(e.id, "hit2", 8'(hit2), 8'(e.h2));
                chk(e.id, "fwd1", 8'(fwd1), 8'(e.f1));
                chk(e.id, "fwd2", 8'(fwd2), 8'(e.f2));
                chk(e.id, "stall_req", 8'(stall_req), 8'(e.sr));
            end
        end
    end

    int vid = 0;

    task automatic vec(
        input logic r, s, f, vi,
        input logic [4:0] a1, a2, w,
        input logic [1:0] rs, tn,
        input logic [4:0] c1, c2,
        input logic ev,
        input logic [4:0] e1, e2, ew,
        input logic [1:0] er, et,
        input logic eh1, eh2, ef1, ef2, esr
    );
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; valid_i = vi;
        ra1_i = a1; ra2_i = a2; wa_i = w; res_i = rs; tnew_i = tn;
        q1 = c1; q2 = c2;
        vid++;
        e.id = vid; e.v = ev; e.ra1 = e1; e.ra2 = e2; e.wa = ew;
        e.res = er; e.tnew = et;
        e.h1 = eh1; e.h2 = eh2; e.f1 = ef1; e.f2 = ef2; e.sr = esr;
        sb.push_back(e);
    endtask

    initial begin
        //   r s f v ra1 ra2 wa res tn q1 q2 | v ra1 ra2 wa res tn h1 h2 f1 f2 sr
        // reset with busy inputs
        vec(1,0,0,1, 3, 4, 8, 2, 2, 8, 8,  0, 0, 0, 0, 0, 0, 0,0,0,0,0);
        vec(1,0,0,1, 3, 4, 8, 2, 2, 8, 8,  0, 0, 0, 0, 0, 0, 0,0,0,0,0);
        // normal load, tnew 2 -> 1, then 0 -> 0
        vec(0,0,0,1, 3, 4, 8, 2, 2, 8, 4,  1, 3, 4, 8, 2, 1, 1,0,0,0,1);
        vec(0,0,0,1, 3, 4, 8, 2, 0, 8, 4,  1, 3, 4, 8, 2, 0, 1,0,1,0,0);
        // canonicalisation cases
        vec(0,0,0,1, 1, 2, 0, 1, 1, 0, 0,  1, 1, 2, 0, 0, 0, 0,0,0,0,0);
        vec(0,0,0,0, 5, 6, 9, 1, 3, 9, 9,  0, 5, 6, 0, 0, 2, 0,0,0,0,0);
        vec(0,0,0,1, 0, 0, 9, 0, 0, 9, 9,  1, 0, 0, 0, 0, 0, 0,0,0,0,0);
        // load wa=5 tnew_o=1, then stall 3 edges while inputs move to wa=7
        vec(0,0,0,1, 1, 2, 5, 1, 2, 5, 0,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(0,1,0,1, 7, 7, 7, 1, 3, 5, 7,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(0,1,0,1, 7, 7, 7, 1, 3, 5, 7,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(0,1,0,1, 7, 7, 7, 1, 3, 5, 7,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(0,0,0,1, 7, 7, 7, 1, 3, 5, 7,  1, 7, 7, 7, 1, 2, 0,1,0,0,1);
        // flush beats stall; rst beats stall
        vec(0,0,0,1, 1, 2, 5, 1, 2, 5, 0,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(0,1,1,1, 1, 2, 5, 1, 2, 5, 0,  0, 0, 0, 0, 0, 0, 0,0,0,0,0);
        vec(0,0,0,1, 1, 2, 5, 1, 2, 5, 0,  1, 1, 2, 5, 1, 1, 1,0,0,0,1);
        vec(1,1,0,1, 1, 2, 5, 1, 2, 5, 0,  0, 0, 0, 0, 0, 0, 0,0,0,0,0);
        // saturation and both-hit
        vec(0,0,0,1, 0, 0, 6, 3, 0, 6, 6,  1, 0, 0, 6, 3, 0, 1,1,1,1,0);
        vec(0,0,0,1, 0, 0, 6, 3, 2, 6, 6,  1, 0, 0, 6, 3, 1, 1,1,0,0,1);
        vec(0,0,1,1, 0, 0, 6, 3, 2, 6, 6,  0, 0, 0, 0, 0, 0, 0,0,0,0,0);
        vec(0,0,0,1, 0, 0, 6, 3, 3, 6, 1,  1, 0, 0, 6, 3, 2, 1,0,0,0,1);
        // held state, only q changes: match follows q with no delay
        vec(0,1,0,1, 9, 9, 9, 1, 1, 1, 6,  1, 0, 0, 6, 3, 2, 0,1,0,0,1);
        vec(0,1,0,0, 9, 9, 9, 1, 1, 0, 0,  1, 0, 0, 6, 3, 2, 0,0,0,0,0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #4;
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
